fetch_unit: RTL

Instruction fetch stage for the 16-bit pipelined core: holds the PC, issues word fetches to a variable-latency instruction memory, buffers up to two fetched instructions for decode, and consumes the redirect (taken branch/jump) produced by the execute stage. It feeds the IF/ID boundary with `Instruction` and `PC_Inc` and stops fetching at HALT.

---
 rtl/fetch_unit_pkg.sv | 6 +
 rtl/fetch_buffer.sv | 30 +++
 rtl/fetch_unit.sv | 79 +++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: opcodes, NOP encoding and fetch FSM states shared by the fetch stage
package fetch_unit_pkg;
    localparam logic [4:0]  OPC_HALT  = 5'b00000;
    localparam logic [15:0] INSTR_NOP = 16'h0800;
    typedef enum logic [1:0] {FETCH, DROP, HALTED} fetch_state_t;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry FIFO of {instr, pc_inc} between fetch and decode
module fetch_buffer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  logic [31:0] din,
    output logic [1:0]  count,
    output logic [31:0] head
);
    logic [31:0] mem [2];
    logic        rd;
    logic        wr;
    assign head = mem[rd];
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd    <= 1'b0;
            wr    <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                mem[wr] <= din;
                wr      <= ~wr;
            end
            if (pop) rd <= ~rd;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, variable-latency instruction fetch, 2-deep decode buffer, redirect and HALT handling
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] Instruction,
    output logic [15:0] PC_Inc,
    output logic        inst_valid,
    output logic        halted
);
    fetch_state_t state;
    fetch_state_t state_next;
    logic [15:0]  pc;
    logic [15:0]  pc_next;
    logic [15:0]  addr;
    logic [15:0]  addr_next;
    logic         run;
    logic [1:0]   count;
    logic [31:0]  head;
    logic         push;
    logic         pop;
    // run holds the request off for the first cycle after reset releases
    assign imem_req    = run && (state == DROP || (state == FETCH && count != 2'd2));
    assign imem_addr   = addr;
    assign push        = state == FETCH && imem_req && imem_ack;
    assign inst_valid  = count != 2'd0;
    assign pop         = inst_valid && !stall;
    assign halted      = state == HALTED;
    assign Instruction = inst_valid ? head[31:16] : INSTR_NOP;
    assign PC_Inc      = inst_valid ? head[15:0] : 16'h0000;
    // a dropped request keeps its old address on the bus until it is acknowledged
    always_comb begin
        state_next = state;
        pc_next    = pc;
        if (redirect_valid) begin
            pc_next    = redirect_pc;
            state_next = (imem_req && !imem_ack) ? DROP : FETCH;
        end else if (state == DROP) begin
            state_next = imem_ack ? FETCH : DROP;
        end else if (push) begin
            pc_next    = pc + 16'd2;
            state_next = imem_rdata[15:11] == OPC_HALT ? HALTED : FETCH;
        end
        addr_next = state_next == DROP ? addr : pc_next;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FETCH;
            pc    <= RESET_PC;
            addr  <= RESET_PC;
            run   <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            addr  <= addr_next;
            run   <= 1'b1;
        end
    end
    fetch_buffer u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ({imem_rdata, pc + 16'd2}),
        .count (count),
        .head  (head)
    );
endmodule
